// File: rtl/mem_test_pkg.sv
// Shared types for the memory write/verify sequencer: FSM state encoding and run-mode values.
package mem_test_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_W_SETUP = 3'd1,
    ST_W_PULSE = 3'd2,
    ST_R_ADDR  = 3'd3,
    ST_R_WAIT  = 3'd4,
    ST_R_CMP   = 3'd5,
    ST_DONE    = 3'd6
  } state_t;

  localparam logic RUN_STEP = 1'b0;
  localparam logic RUN_FREE = 1'b1;

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchronizer for a raw (externally debounced) button plus a registered
// one-cycle rising-edge pulse; the pulse appears three clocks after the button rises.
module btn_sync_edge (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_btn,
  output logic o_pulse
);

  logic r_sync1;
  logic r_sync2;
  logic r_prev;
  logic r_pulse;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
      r_pulse <= 1'b0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      r_pulse <= r_sync2 & ~r_prev;
    end
  end

  assign o_pulse = r_pulse;

endmodule

// File: rtl/mem_test_sequencer.sv
// Write/verify RAM test sequencer: writes DATA_SEED+k to BASE_ADDR+k*ADDR_STRIDE, reads back
// and compares, either single-stepped from a button or free-running.
//
// state    | meaning
// IDLE     | waiting for start, bus parked at zero
// W_SETUP  | address/data of entry k presented, we low (step-gated)
// W_PULSE  | one-cycle write strobe for entry k
// R_ADDR   | read address of entry k presented (step-gated)
// R_WAIT   | RAM read latency
// R_CMP    | compare data_in with expected value
// DONE     | results held until next start
module mem_test_sequencer #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int NUM_ENTRIES = 8,
  parameter int BASE_ADDR   = 0,
  parameter int ADDR_STRIDE = 16,
  parameter int DATA_SEED   = 1
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               step_btn,
  input  logic                               run_mode,
  input  logic                               start,
  output logic [ADDR_W-1:0]                  addr,
  output logic                               we,
  output logic [DATA_W-1:0]                  data_out,
  input  logic [DATA_W-1:0]                  data_in,
  output logic                               busy,
  output logic                               done,
  output logic                               pass,
  output logic [$clog2(NUM_ENTRIES+1)-1:0]   err_count,
  output logic [ADDR_W-1:0]                  fail_addr
);

  import mem_test_pkg::*;

  localparam int CNT_W = $clog2(NUM_ENTRIES + 1);
  localparam logic [ADDR_W-1:0] BASE_A   = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] STRIDE_A = ADDR_W'(ADDR_STRIDE);
  localparam logic [DATA_W-1:0] SEED_D   = DATA_W'(DATA_SEED);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(NUM_ENTRIES - 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_mode;
  logic                w_mode_nxt;
  logic [CNT_W-1:0]    r_left;
  logic [CNT_W-1:0]    w_left_nxt;
  logic [ADDR_W-1:0]   r_addr;
  logic [ADDR_W-1:0]   w_addr_nxt;
  logic [DATA_W-1:0]   r_data;
  logic [DATA_W-1:0]   w_data_nxt;
  logic                r_we;
  logic                w_we_nxt;
  logic                r_busy;
  logic                w_busy_nxt;
  logic                r_done;
  logic                w_done_nxt;
  logic                r_pass;
  logic                w_pass_nxt;
  logic [CNT_W-1:0]    r_err;
  logic [CNT_W-1:0]    w_err_nxt;
  logic [ADDR_W-1:0]   r_fail;
  logic [ADDR_W-1:0]   w_fail_nxt;

  logic w_step;
  logic w_adv;
  logic w_last;

  btn_sync_edge u_step_sync (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_btn   (step_btn),
    .o_pulse (w_step)
  );

  assign w_adv  = (r_mode == RUN_FREE) || w_step;
  assign w_last = (r_left == '0);

  // r_left counts down remaining entries; r_addr/r_data step incrementally and
  // r_data doubles as the expected read-back value during the verify pass.
  always_comb begin
    w_state_nxt = r_state;
    w_mode_nxt  = r_mode;
    w_left_nxt  = r_left;
    w_addr_nxt  = r_addr;
    w_data_nxt  = r_data;
    w_we_nxt    = 1'b0;
    w_busy_nxt  = r_busy;
    w_done_nxt  = r_done;
    w_pass_nxt  = r_pass;
    w_err_nxt   = r_err;
    w_fail_nxt  = r_fail;

    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          w_state_nxt = ST_W_SETUP;
          w_mode_nxt  = run_mode;
          w_left_nxt  = LAST_CNT;
          w_addr_nxt  = BASE_A;
          w_data_nxt  = SEED_D;
          w_busy_nxt  = 1'b1;
          w_done_nxt  = 1'b0;
          w_pass_nxt  = 1'b0;
          w_err_nxt   = '0;
          w_fail_nxt  = '0;
        end
      end
      ST_W_SETUP: begin
        if (w_adv) begin
          w_state_nxt = ST_W_PULSE;
          w_we_nxt    = 1'b1;
        end
      end
      ST_W_PULSE: begin
        if (w_last) begin
          w_state_nxt = ST_R_ADDR;
          w_left_nxt  = LAST_CNT;
          w_addr_nxt  = BASE_A;
          w_data_nxt  = SEED_D;
        end else begin
          w_state_nxt = ST_W_SETUP;
          w_left_nxt  = r_left - 1'b1;
          w_addr_nxt  = r_addr + STRIDE_A;
          w_data_nxt  = r_data + 1'b1;
        end
      end
      ST_R_ADDR: begin
        if (w_adv) w_state_nxt = ST_R_WAIT;
      end
      ST_R_WAIT: begin
        w_state_nxt = ST_R_CMP;
      end
      ST_R_CMP: begin
        if (data_in != r_data) begin
          if (r_err == '0) w_fail_nxt = r_addr;
          if (r_err != '1) w_err_nxt = r_err + 1'b1;
        end
        if (w_last) begin
          w_state_nxt = ST_DONE;
          w_addr_nxt  = '0;
          w_data_nxt  = '0;
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
          w_pass_nxt  = (w_err_nxt == '0);
        end else begin
          w_state_nxt = ST_R_ADDR;
          w_left_nxt  = r_left - 1'b1;
          w_addr_nxt  = r_addr + STRIDE_A;
          w_data_nxt  = r_data + 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_addr_nxt  = '0;
        w_data_nxt  = '0;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_mode  <= RUN_STEP;
      r_left  <= '0;
      r_addr  <= '0;
      r_data  <= '0;
      r_we    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
      r_err   <= '0;
      r_fail  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_mode  <= w_mode_nxt;
      r_left  <= w_left_nxt;
      r_addr  <= w_addr_nxt;
      r_data  <= w_data_nxt;
      r_we    <= w_we_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_pass  <= w_pass_nxt;
      r_err   <= w_err_nxt;
      r_fail  <= w_fail_nxt;
    end
  end

  assign addr      = r_addr;
  assign we        = r_we;
  assign data_out  = r_data;
  assign busy      = r_busy;
  assign done      = r_done;
  assign pass      = r_pass;
  assign err_count = r_err;
  assign fail_addr = r_fail;

endmodule
